flash_read_responder: RTL and testbench
=======================================

// Module: flash_read_responder
// PURPOSE
//  Responder end of the flash-read handshake driven by the song address FSM.
//  Accepts one word request (start/read/address/byteenable), runs a single Avalon-MM pipelined read
//  on the flash controller port, and returns the 32-bit word with a one-cycle done pulse (the FSM's endFlash).
//  Sits between the address FSM and the flash IP; includes a timeout so a hung bus cannot stall playback.
// PARAMETERS
//  ADDR_W          23    word-address width, requester and flash sides
//  DATA_W          32    data width; byteenable width = DATA_W/8
//  TIMEOUT_CYCLES  1024  max cycles in ISSUE+WAIT_DATA before the request is aborted
// PORTS
//  clk                   in   1         system clock, all logic on posedge
//  reset                 in   1         synchronous, active-high
//  start                 in   1         request; requester holds high until it sees done
//  read                  in   1         read qualifier; request accepted only if start & read
//  address               in   ADDR_W    requested word address
//  byteenable            in   DATA_W/8  byte lanes, forwarded to flash unchanged
//  done                  out  1         one-cycle pulse: data valid (endFlash)
//  data                  out  DATA_W    returned word, held until next done
//  err                   out  1         one-cycle pulse coincident with done on timeout
//  flash_mem_read        out  1         Avalon read strobe
//  flash_mem_address     out  ADDR_W    Avalon address
//  flash_mem_byteenable  out  DATA_W/8  Avalon byteenable
//  flash_mem_waitrequest in   1         Avalon stall
//  flash_mem_readdata    in   DATA_W    Avalon read data
//  flash_mem_readdatavalid in 1         Avalon read data valid
// BEHAVIOUR
//  Reset: state=IDLE; done, err, flash_mem_read = 0; data, flash_mem_address, flash_mem_byteenable = 0;
//   timeout counter = 0. Reset mid-operation aborts; no done issued; late readdatavalid is ignored.
//  States: IDLE -> ISSUE -> WAIT_DATA -> DONE -> RELEASE -> IDLE.
//  IDLE: on start&read, register address/byteenable into flash_mem_*, clear counter, go ISSUE.
//  ISSUE: flash_mem_read=1, address/byteenable stable; if !waitrequest this cycle, go WAIT_DATA
//   (read drops next cycle). readdatavalid in ISSUE is ignored (Avalon gives >=1 cycle latency).
//  WAIT_DATA: on readdatavalid, data<=flash_mem_readdata, go DONE.
//  DONE: done=1 for exactly one cycle, go RELEASE.
//  RELEASE: wait for start==0, then IDLE; blocks re-trigger from the requester's held start.
//  Latency (no stall, readdata 1 cycle after accept): start seen at T0, read at T1,
//   readdatavalid T2, done T3.
//  Timeout: counter increments each cycle in ISSUE or WAIT_DATA; at count == TIMEOUT_CYCLES-1 go DONE
//   with data=0, err=1, flash_mem_read forced 0. Counter saturates, never wraps.
//  Exactly one outstanding read; a new start is not sampled outside IDLE.
//  start without read in IDLE: no action.
// CONFIGURATION
//  FLASH_WORD_CACHE_EN defined: one-entry cache {valid, tag[ADDR_W], word}. Filled on every successful
//   (non-timeout) readdatavalid. In IDLE, start&read with valid && address==tag -> skip bus,
//   data<=word, go DONE (done at T1, flash_mem_read never asserted).
//   valid cleared by reset and by any timeout.
//  Not defined: no cache storage; every request goes to the bus as above.
// TESTING
//  1 Basic: start=1,addr=0x00010,ws=0, readdatavalid 1 cycle after accept, readdata=0xA1B2C3D4
//    -> flash_mem_read one cycle, done at T3, data=0xA1B2C3D4, err=0.
//  2 Stall: waitrequest high 5 cycles -> flash_mem_read and address held 6 cycles; done follows valid by 1.
//  3 Timeout: TIMEOUT_CYCLES=16, readdatavalid never -> done&err at cycle 16 after T0, data=0, back to IDLE
//    after start drops.
//  4 Held start: start stays high 4 cycles after done -> exactly one done, no second read.
//  5 Reset in WAIT_DATA then readdatavalid arrives -> no done, outputs at reset values.
//  6 FLASH_WORD_CACHE_EN: read 0x7FFFF twice -> second done at T1, no flash_mem_read;
//    after timeout, repeat goes to bus.

Source files
------------

// File: rtl/flash_read_responder.sv
// Responder for the song-address FSM flash handshake: one Avalon-MM pipelined read per request, with timeout.
// Optional one-word result cache enabled by defining FLASH_WORD_CACHE_EN.
module flash_read_responder #(
    parameter int ADDR_W         = 23,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  read,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W/8-1:0]   byteenable,
    output logic                  done,
    output logic [DATA_W-1:0]     data,
    output logic                  err,
    output logic                  flash_mem_read,
    output logic [ADDR_W-1:0]     flash_mem_address,
    output logic [DATA_W/8-1:0]   flash_mem_byteenable,
    input  logic                  flash_mem_waitrequest,
    input  logic [DATA_W-1:0]     flash_mem_readdata,
    input  logic                  flash_mem_readdatavalid
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_DATA = 3'd2,
        DONE      = 3'd3,
        RELEASE   = 3'd4
    } state_t;

    state_t                state_q;
    logic                  done_q;
    logic                  err_q;
    logic                  rd_q;
    logic [DATA_W-1:0]     data_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W/8-1:0]   be_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic                  timeout_d;

`ifdef FLASH_WORD_CACHE_EN
    logic                  cache_vld_q;
    logic [ADDR_W-1:0]     cache_tag_q;
    logic [DATA_W-1:0]     cache_word_q;
    logic                  cache_hit;

    assign cache_hit = cache_vld_q && (address == cache_tag_q);
`endif

    // Saturating cycle count; the abort fires when the next count reaches the last allowed cycle.
    always_comb begin
        cnt_d     = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + 1'b1;
        timeout_d = (cnt_d == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            cnt_q   <= '0;
`ifdef FLASH_WORD_CACHE_EN
            cache_vld_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && read) begin
`ifdef FLASH_WORD_CACHE_EN
                        if (cache_hit) begin
                            data_q  <= cache_word_q;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            addr_q  <= address;
                            be_q    <= byteenable;
                            cnt_q   <= '0;
                            rd_q    <= 1'b1;
                            state_q <= ISSUE;
                        end
`else
                        addr_q  <= address;
                        be_q    <= byteenable;
                        cnt_q   <= '0;
                        rd_q    <= 1'b1;
                        state_q <= ISSUE;
`endif
                    end
                end
                ISSUE: begin
                    cnt_q <= cnt_d;
                    if (timeout_d) begin
                        rd_q    <= 1'b0;
                        data_q  <= '0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= DONE;
`ifdef FLASH_WORD_CACHE_EN
                        cache_vld_q <= 1'b0;
`endif
                    end else if (!flash_mem_waitrequest) begin
                        rd_q    <= 1'b0;
                        state_q <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    cnt_q <= cnt_d;
                    // A real response in the final cycle still counts as success.
                    if (flash_mem_readdatavalid) begin
                        data_q  <= flash_mem_readdata;
                        done_q  <= 1'b1;
                        state_q <= DONE;
`ifdef FLASH_WORD_CACHE_EN
                        cache_vld_q  <= 1'b1;
                        cache_tag_q  <= addr_q;
                        cache_word_q <= flash_mem_readdata;
`endif
                    end else if (timeout_d) begin
                        data_q  <= '0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= DONE;
`ifdef FLASH_WORD_CACHE_EN
                        cache_vld_q <= 1'b0;
`endif
                    end
                end
                DONE: begin
                    state_q <= RELEASE;
                end
                RELEASE: begin
                    if (!start) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    rd_q    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign done                 = done_q;
    assign err                  = err_q;
    assign data                 = data_q;
    assign flash_mem_read       = rd_q;
    assign flash_mem_address    = addr_q;
    assign flash_mem_byteenable = be_q;

endmodule

// File: tb/tb_flash_read_responder.sv
// Bench for flash_read_responder: reactive Avalon slave, per-cycle behavioural model, directed requests.
// Cache expectations follow FLASH_WORD_CACHE_EN when the bench is built with it.
module tb_flash_read_responder;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        read = 1'b0;
    logic [22:0] address = '0;
    logic [3:0]  byteenable = '0;
    logic        done;
    logic [31:0] data;
    logic        err;
    logic        flash_mem_read;
    logic [22:0] flash_mem_address;
    logic [3:0]  flash_mem_byteenable;
    logic        flash_mem_waitrequest = 1'b0;
    logic [31:0] flash_mem_readdata = '0;
    logic        flash_mem_readdatavalid = 1'b0;

    flash_read_responder #(.ADDR_W(23), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .read(read), .address(address),
        .byteenable(byteenable), .done(done), .data(data), .err(err),
        .flash_mem_read(flash_mem_read), .flash_mem_address(flash_mem_address),
        .flash_mem_byteenable(flash_mem_byteenable),
        .flash_mem_waitrequest(flash_mem_waitrequest),
        .flash_mem_readdata(flash_mem_readdata),
        .flash_mem_readdatavalid(flash_mem_readdatavalid)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    logic rst_seen = 1'b0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= reset;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Slave configuration for the current request.
    int          cfg_ws = 0, cfg_lat = 1;
    bit          cfg_never = 0, cfg_spur = 0;
    logic [31:0] cfg_rdata = '0;
    int          sl_rw = 0, sl_acc = 0;
    bit          sl_pend = 0;

    always @(negedge clk) begin
        flash_mem_readdatavalid = 1'b0;
        flash_mem_readdata      = 32'h5A5A5A5A;
        if (sl_pend && cyc == sl_acc + cfg_lat) begin
            flash_mem_readdatavalid = 1'b1;
            flash_mem_readdata      = cfg_rdata;
            sl_pend = 0;
        end
        if (flash_mem_read === 1'b1) begin
            flash_mem_waitrequest = (sl_rw < cfg_ws);
            sl_rw++;
            if (flash_mem_waitrequest && cfg_spur) begin
                flash_mem_readdatavalid = 1'b1;
                flash_mem_readdata      = 32'h0BAD0BAD;
            end
            if (!flash_mem_waitrequest) begin
                sl_pend = !cfg_never;
                sl_acc  = cyc;
            end
        end else begin
            flash_mem_waitrequest = 1'b0;
            sl_rw = 0;
        end
    end

    // Model of the current request, described by its timing parameters relative to T0.
    bit          exp_active = 0, exp_hit = 0, exp_never = 0;
    int          exp_t0 = 0, exp_ws = 0, exp_lat = 0;
    logic [22:0] exp_addr = '0;
    logic [3:0]  exp_be = '0;
    logic [31:0] exp_rdata = '0;
    logic [31:0] model_data = '0;
    bit          c_vld = 0;
    logic [22:0] c_tag = '0;
    logic [31:0] c_word = '0;
    int          n_done = 0, n_read = 0, obs_k = -1;
    logic [31:0] obs_data = '0;
    logic        obs_err = 1'b0;

    always @(negedge clk) begin
        int k, dn, last_rd;
        bit e_read, e_done, e_err;
        if (rst_seen) begin
            exp_active = 0;
            model_data = '0;
            c_vld      = 0;
            chk("rst_done", done, 1'b0);
            chk("rst_err", err, 1'b0);
            chk("rst_read", flash_mem_read, 1'b0);
            chk("rst_data", data, 32'h0);
            chk("rst_addr", flash_mem_address, 23'h0);
            chk("rst_be", flash_mem_byteenable, 4'h0);
        end else begin
            k = cyc - exp_t0;
            e_read = 0; e_done = 0; e_err = 0;
            if (exp_active) begin
                if (exp_hit) begin
                    e_done = (k == 1);
                end else begin
                    dn = exp_never ? 1000000 : 2 + exp_ws + exp_lat;
                    if (dn < TO) begin
                        e_done = (k == dn);
                    end else begin
                        e_done = (k == TO);
                        e_err  = e_done;
                    end
                    last_rd = (1 + exp_ws < TO - 1) ? 1 + exp_ws : TO - 1;
                    e_read  = (k >= 1) && (k <= last_rd);
                end
                if (e_done) begin
                    if (exp_hit) begin
                        model_data = c_word;
                    end else if (e_err) begin
                        model_data = '0;
                        c_vld      = 0;
                    end else begin
                        model_data = exp_rdata;
                        c_vld      = 1;
                        c_tag      = exp_addr;
                        c_word     = exp_rdata;
                    end
                end
            end
            chk("done", done, e_done);
            chk("err", err, e_err);
            chk("flash_read", flash_mem_read, e_read);
            chk("data_hold", data, model_data);
            if (e_read) begin
                chk("flash_addr", flash_mem_address, exp_addr);
                chk("flash_be", flash_mem_byteenable, exp_be);
            end
            if (done === 1'b1) begin
                n_done++;
                obs_k    = k;
                obs_data = data;
                obs_err  = err;
            end
            if (flash_mem_read === 1'b1) n_read++;
        end
    end

    task automatic do_req(input logic [22:0] a, input logic [3:0] be, input int ws, input int lat,
                          input bit nev, input logic [31:0] rd, input bit spur, input int hold);
        bit got;
        @(negedge clk);
        cfg_ws = ws; cfg_lat = lat; cfg_never = nev; cfg_rdata = rd; cfg_spur = spur;
        exp_addr = a; exp_be = be; exp_ws = ws; exp_lat = lat; exp_never = nev; exp_rdata = rd;
`ifdef FLASH_WORD_CACHE_EN
        exp_hit = c_vld && (c_tag == a);
`else
        exp_hit = 0;
`endif
        exp_t0 = cyc; exp_active = 1; n_done = 0; n_read = 0; obs_k = -1;
        start = 1'b1; read = 1'b1; address = a; byteenable = be;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = (done === 1'b1);
        end
        chk("req_done_seen", got, 1'b1);
        repeat (hold) @(negedge clk);
        start = 1'b0; read = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("init_done", done, 1'b0);
        chk("init_read", flash_mem_read, 1'b0);

        // Basic read
        do_req(23'h00010, 4'hF, 0, 1, 0, 32'hA1B2C3D4, 0, 0);
        chk("t1_done_k", obs_k, 3);
        chk("t1_data", obs_data, 32'hA1B2C3D4);
        chk("t1_err", obs_err, 1'b0);
        chk("t1_reads", n_read, 1);

        // Stall with spurious valid during ISSUE
        do_req(23'h00123, 4'h3, 5, 2, 0, 32'h11223344, 1, 0);
        chk("t2_reads", n_read, 6);
        chk("t2_done_k", obs_k, 9);
        chk("t2_data", obs_data, 32'h11223344);

        // Timeout
        do_req(23'h00200, 4'hF, 0, 1, 1, 32'h99999999, 0, 0);
        chk("t3_done_k", obs_k, 16);
        chk("t3_err", obs_err, 1'b1);
        chk("t3_data", obs_data, 32'h0);

        // Start held after done
        do_req(23'h00300, 4'hC, 1, 3, 0, 32'hCAFEF00D, 0, 4);
        chk("t4_dones", n_done, 1);
        chk("t4_reads", n_read, 2);
        chk("t4_done_k", obs_k, 6);

        // Reset during WAIT_DATA, response arrives afterwards
        @(negedge clk);
        cfg_ws = 0; cfg_lat = 6; cfg_never = 0; cfg_rdata = 32'h77777777; cfg_spur = 0;
        exp_addr = 23'h00500; exp_be = 4'hF; exp_ws = 0; exp_lat = 6; exp_never = 0;
        exp_rdata = 32'h77777777; exp_hit = 0;
        exp_t0 = cyc; exp_active = 1; n_done = 0; n_read = 0;
        start = 1'b1; read = 1'b1; address = 23'h00500; byteenable = 4'hF;
        repeat (3) @(negedge clk);
        reset = 1'b1; start = 1'b0; read = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("t5_dones", n_done, 0);
        chk("t5_data", data, 32'h0);

        // Start without read
        n_done = 0; n_read = 0;
        start = 1'b1; read = 1'b0; address = 23'h00600;
        repeat (4) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("t7_reads", n_read, 0);
        chk("t7_dones", n_done, 0);

        // Repeat read of one address, then after a timeout
        do_req(23'h7FFFF, 4'hF, 0, 1, 0, 32'h13572468, 0, 0);
        chk("t6a_done_k", obs_k, 3);
        do_req(23'h7FFFF, 4'hF, 0, 1, 0, 32'h13572468, 0, 0);
`ifdef FLASH_WORD_CACHE_EN
        chk("t6b_done_k", obs_k, 1);
        chk("t6b_reads", n_read, 0);
`else
        chk("t6b_done_k", obs_k, 3);
        chk("t6b_reads", n_read, 1);
`endif
        chk("t6b_data", obs_data, 32'h13572468);
        do_req(23'h00400, 4'hF, 0, 1, 1, 32'h0, 0, 0);
        chk("t6c_err", obs_err, 1'b1);
        do_req(23'h7FFFF, 4'h5, 2, 1, 0, 32'h2468ACE0, 0, 0);
        chk("t6d_done_k", obs_k, 5);
        chk("t6d_reads", n_read, 3);
        chk("t6d_data", obs_data, 32'h2468ACE0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end
endmodule
